bus_grant_sequencer: RTL and testbench
======================================

# bus_grant_sequencer

Round-robin arbiter and sequencer for the 9-slot select bus in the processor. Up to nine requesters share one resource. The block picks one at a time and drives a registered 4-bit grant index, which the existing 4-to-9 one-hot decoder turns into per-slot select lines. It holds each grant until the owner signals completion, drops its request, or exceeds a hold-time limit, then rotates priority to the next slot.

## Interface
- NREQ, 9: number of requesters; slots 0..NREQ-1.
- IDXW, 4: grant index width; must satisfy 2^IDXW >= NREQ.
- TIMEOUT, 15: maximum cycles a grant may be held; valid range 1..255.
- clk input 1: single clock, rising edge.
- rst_n input 1: asynchronous, active-low reset.
- req input NREQ: per-slot request level; bit i set means slot i wants the bus.
- done input NREQ: per-slot completion pulse. Only the bit of the current grantee is honoured.
- grant_idx output IDXW: registered index of the current or last grantee; feeds the decoder.
- grant_vld output 1: high while grant_idx is a live grant.
- busy output 1: high whenever the FSM is not in IDLE.
- timeout_err output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States:
  - IDLE
  - GRANT
  - RELEASE
- Round-robin pointer `ptr` (IDXW bits) marks the highest-priority slot.
- The winner is the first slot with req set, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
- IDLE:
  - If any req bit is set, load grant_idx with the winner, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (evaluate in this priority order):
  1. done[grant_idx] = 1 → go to RELEASE.
  2. req[grant_idx] = 0 → abort; go to RELEASE.
  3. hold_cnt = TIMEOUT-1 → pulse timeout_err and go to RELEASE.
  4. Otherwise increment hold_cnt and stay in GRANT.
- On every exit from GRANT, set ptr = grant_idx+1, wrapping NREQ-1 → 0.
- RELEASE lasts exactly one cycle with grant_vld = 0:
  - If any req bit is set, load the winner using the already-updated ptr and go straight to GRANT.
  - Otherwise go to IDLE.
- done bits of non-grantees are ignored in every state. done in IDLE or RELEASE is ignored.
- req changes in non-granted slots never disturb a live grant.
- grant_idx holds its last value in IDLE and RELEASE.
- hold_cnt is 8 bits and saturates. It is only meaningful in GRANT.

## Timing
- Reset values:
  - grant_idx = 0
  - grant_vld = 0
  - busy = 0
  - timeout_err = 0
  - ptr = 0
  - hold_cnt = 0
  - state = IDLE
- Reset is asynchronous and takes effect mid-grant. The grant is dropped the same instant with no timeout_err.
- Request latency: req seen in IDLE at edge N → grant_vld = 1 and grant_idx valid after edge N.
- Release latency:
  - done sampled at edge M → grant_vld = 0 after M (RELEASE).
  - Next grant is valid after M+1.
  - Minimum gap between grants is one cycle.
- Timeout: a grant is live for exactly TIMEOUT cycles. timeout_err is high during the RELEASE cycle that follows.
- Simultaneous done and timeout in the same cycle: done wins, and no timeout_err.
- busy = grant_vld OR (state == RELEASE).
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared header holds:
  - NREQ, IDXW, TIMEOUT defaults
  - 2-bit state encodings: IDLE = 0, GRANT = 1, RELEASE = 2
- Sub-module rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req[NREQ-1:0], ptr[IDXW-1:0].
  - Outputs: any_req, winner[IDXW-1:0].
- Instantiate rr_pick once.
- The decoder stays outside this block. Integration connects grant_idx to the decoder address and gates the decoder outputs with grant_vld.

## Test plan
- Single requester: req = 9'h004 from IDLE → grant_idx = 2 and grant_vld = 1 one cycle later. done[2] → grant_vld = 0 next cycle, then IDLE and busy = 0.
- Full rotation: req = 9'h1FF held, each grantee pulses done on its second cycle → grant order 0, 1, …, 8, 0, with exactly one grant_vld = 0 cycle between grants.
- Wrap and skip: ptr = 8, req = 9'h003 → grant goes to slot 0, then to slot 1.
- Timeout: req[5] held with no done, TIMEOUT = 15 → grant_vld high for 15 cycles, then timeout_err pulses one cycle. Next grant goes to slot 6 or later.
- Ignored done and abort:
  - done[3] while slot 1 is granted → no effect.
  - Dropping req[1] → RELEASE on the next edge, no timeout_err.
- Async reset mid-grant: rst_n low during GRANT of slot 4 → all outputs return to reset values immediately. After release, the first grant goes to the lowest active slot from ptr = 0.

Source files
------------

// File: rtl/bus_grant_sequencer_pkg.sv
// bus_grant_sequencer_pkg: shared defaults and FSM state encoding for the grant sequencer
package bus_grant_sequencer_pkg;
    localparam int NREQ_DEF    = 9;
    localparam int IDXW_DEF    = 4;
    localparam int TIMEOUT_DEF = 15;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;
endpackage

// File: rtl/bus_grant_sequencer_rr_pick.sv
// bus_grant_sequencer_rr_pick: rotate-and-priority-encode, first requester at or after ptr
module bus_grant_sequencer_rr_pick
    import bus_grant_sequencer_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            any_req_o,
    output logic [IDXW-1:0] winner_o
);
    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);
    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] off;
    logic [IDXW:0]   sum;
    logic            found;
    assign any_req_o = |req_i;
    always_comb begin
        rot   = NREQ'({req_i, req_i} >> ptr_i);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                off   = IDXW'(i);
                found = 1'b1;
            end
        end
        sum      = {1'b0, ptr_i} + {1'b0, off};
        winner_o = sum >= NREQ_W ? IDXW'(sum - NREQ_W) : sum[IDXW-1:0];
    end
endmodule

// File: rtl/bus_grant_sequencer.sv
// bus_grant_sequencer: round-robin grant FSM holding each grant until done, abort or timeout
module bus_grant_sequencer
    import bus_grant_sequencer_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int IDXW    = IDXW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] done_i,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_vld_o,
    output logic            busy_o,
    output logic            timeout_err_o
);
    localparam int            NPAD   = 1 << IDXW;
    localparam logic [7:0]    TO_CNT = 8'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST = IDXW'(NREQ - 1);
    state_e          state_q;
    logic [IDXW-1:0] grant_idx_q, ptr_q, ptr_d, winner;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            grant_vld_q, timeout_err_q, any_req;
    logic [NPAD-1:0] req_pad, done_pad;
    logic            g_done, g_req, g_exit;
    bus_grant_sequencer_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .any_req_o (any_req),
        .winner_o  (winner)
    );
    // padding lets grant_idx index the full IDXW range without going out of bounds
    assign req_pad    = NPAD'(req_i);
    assign done_pad   = NPAD'(done_i);
    assign g_done     = done_pad[grant_idx_q];
    assign g_req      = req_pad[grant_idx_q];
    assign g_exit     = g_done || !g_req || hold_cnt_q == TO_CNT;
    assign ptr_d      = grant_idx_q == LAST ? '0 : grant_idx_q + 1'b1;
    assign hold_cnt_d = hold_cnt_q + 8'(hold_cnt_q != 8'hFF);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_idx_q   <= '0;
            grant_vld_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RELEASE: begin
                    if (any_req) begin
                        grant_idx_q <= winner;
                        hold_cnt_q  <= '0;
                        grant_vld_q <= 1'b1;
                        state_q     <= ST_GRANT;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (g_exit) begin
                        // done and abort both outrank the timeout, so only a pure timeout flags an error
                        timeout_err_q <= !g_done && g_req;
                        grant_vld_q   <= 1'b0;
                        ptr_q         <= ptr_d;
                        state_q       <= ST_RELEASE;
                    end else begin
                        hold_cnt_q    <= hold_cnt_d;
                    end
                end
                default: begin
                    grant_vld_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
    assign grant_idx_o   = grant_idx_q;
    assign grant_vld_o   = grant_vld_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = state_q != ST_IDLE;
endmodule

// File: tb/tb_bus_grant_sequencer.sv
// tb_bus_grant_sequencer: table-driven and hand-sequenced checks of the round-robin grant sequencer
module tb_bus_grant_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] req, done;
    logic [3:0] grant_idx;
    logic       grant_vld, busy, timeout_err;
    int         checks = 0;
    int         errors = 0;

    bus_grant_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .done_i        (done),
        .grant_idx_o   (grant_idx),
        .grant_vld_o   (grant_vld),
        .busy_o        (busy),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] req;
        logic [8:0] done;
        logic [3:0] idx;
        logic       vld;
        logic       bsy;
        logic       to;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] idx, input logic vld,
                           input logic bsy, input logic to);
        chk({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".grant_vld"}, 32'(grant_vld), 32'(vld));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{9'h004, 9'h000, 4'd2, 1'b1, 1'b1, 1'b0};
        tv[1]  = '{9'h004, 9'h004, 4'd2, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{9'h000, 9'h000, 4'd2, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{9'h000, 9'h000, 4'd2, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{9'h002, 9'h000, 4'd1, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{9'h002, 9'h008, 4'd1, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{9'h00A, 9'h008, 4'd1, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{9'h008, 9'h000, 4'd1, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{9'h008, 9'h000, 4'd3, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{9'h000, 9'h000, 4'd3, 1'b0, 1'b1, 1'b0};
        tv[10] = '{9'h000, 9'h000, 4'd3, 1'b0, 1'b0, 1'b0};
        tv[11] = '{9'h080, 9'h000, 4'd7, 1'b1, 1'b1, 1'b0};
        tv[12] = '{9'h080, 9'h080, 4'd7, 1'b0, 1'b1, 1'b0};
        tv[13] = '{9'h003, 9'h000, 4'd0, 1'b1, 1'b1, 1'b0};
        tv[14] = '{9'h003, 9'h001, 4'd0, 1'b0, 1'b1, 1'b0};
        tv[15] = '{9'h003, 9'h000, 4'd1, 1'b1, 1'b1, 1'b0};
        tv[16] = '{9'h000, 9'h000, 4'd1, 1'b0, 1'b1, 1'b0};
        tv[17] = '{9'h000, 9'h000, 4'd1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // single requester, ignored done, abort, wrap from ptr 8 and skip
        for (int i = 0; i < 18; i++) begin
            req  = tv[i].req;
            done = tv[i].done;
            step();
            chk_out($sformatf("vec%0d", i), tv[i].idx, tv[i].vld, tv[i].bsy, tv[i].to);
        end

        // timeout: slot 5 live for exactly 15 cycles, ptr starts at 2
        req  = 9'h020;
        done = '0;
        step();
        chk_out("to_grant", 4'd5, 1'b1, 1'b1, 1'b0);
        req = 9'h120;
        for (int k = 1; k < 15; k++) begin
            step();
            chk_out($sformatf("to_hold%0d", k), 4'd5, 1'b1, 1'b1, 1'b0);
        end
        step();
        chk_out("to_release", 4'd5, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("to_next", 4'd8, 1'b1, 1'b1, 1'b0);
        req  = '0;
        done = 9'h100;
        step();
        chk_out("to_next_rel", 4'd8, 1'b0, 1'b1, 1'b0);
        done = '0;
        step();
        chk_out("to_idle", 4'd8, 1'b0, 1'b0, 1'b0);

        // done arriving on the timeout cycle wins with no timeout_err
        req = 9'h001;
        step();
        chk_out("sim_grant", 4'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) begin
            step();
            chk("sim_hold_vld", 32'(grant_vld), 32'd1);
        end
        done = 9'h001;
        step();
        chk_out("sim_release", 4'd0, 1'b0, 1'b1, 1'b0);
        req  = '0;
        done = '0;
        step();
        chk_out("sim_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // async reset in the middle of slot 4's grant, ptr is 1
        req = 9'h010;
        step();
        chk_out("ar_grant", 4'd4, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("ar_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        req = 9'h1FF;
        #2 rst_n = 1'b1;

        // full rotation from ptr 0, done on each grantee's second cycle
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out($sformatf("rot%0d_g", k), 4'(k % 9), 1'b1, 1'b1, 1'b0);
            step();
            chk_out($sformatf("rot%0d_h", k), 4'(k % 9), 1'b1, 1'b1, 1'b0);
            done = 9'(1 << (k % 9));
            step();
            chk_out($sformatf("rot%0d_r", k), 4'(k % 9), 1'b0, 1'b1, 1'b0);
            done = '0;
        end
        req = '0;
        step();
        chk_out("rot_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
